// File: rtl/au_lzc_norm_pkg.sv
// rtl/au_lzc_norm_pkg.sv - shared prefix-architecture codes and clogb2 helper
package au_lzc_norm_pkg;

    localparam int SER = 0;
    localparam int BK  = 1;
    localparam int SK  = 2;

    function automatic int clogb2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/au_lzc_norm_prefix.sv
// rtl/au_lzc_norm_prefix.sv - OR-prefix unit: y[i] = |x[i:0], serial, Brent-Kung or Sklansky
module au_lzc_norm_prefix
    import au_lzc_norm_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ARCH  = SK
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    localparam int TOP = (WIDTH > 1) ? (1 << (clogb2(WIDTH) - 1)) : 1;

    always_comb begin
        logic [WIDTH-1:0] p;
        p = x;
        if (ARCH == SER) begin
            for (int i = 1; i < WIDTH; i++) p[i] = p[i] | p[i-1];
        end else if (ARCH == BK) begin
            // up-sweep builds aligned block totals, down-sweep fills the gaps
            for (int s = 1; s < WIDTH; s = s * 2)
                for (int i = 2 * s - 1; i < WIDTH; i = i + 2 * s) p[i] = p[i] | p[i-s];
            for (int s = TOP / 2; s >= 1; s = s / 2)
                for (int i = 3 * s - 1; i < WIDTH; i = i + 2 * s) p[i] = p[i] | p[i-s];
        end else begin
            for (int s = 1; s < WIDTH; s = s * 2)
                for (int i = 0; i < WIDTH; i++)
                    if ((i & s) != 0) p[i] = p[i] | p[(i & ~(s - 1)) - 1];
        end
        y = p;
    end

endmodule

// File: rtl/au_lzc_norm.sv
// rtl/au_lzc_norm.sv - pipelined leading-zero count and normalise; AU_LZC_NORM_PIPE_EN adds a thermometer stage
module au_lzc_norm
    import au_lzc_norm_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ARCH  = SK,
    localparam int CW   = (clogb2(WIDTH + 1) > 1) ? clogb2(WIDTH + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_lzc,
    output logic             out_zero
);

    logic             va, vb;
    logic [WIDTH-1:0] da, db, rev, therm;
    logic [CW-1:0]    lzcb;
    logic             ready_a, ready_b, ready_mid;
    logic             mid_v;
    logic [WIDTH-1:0] mid_d;
    logic [CW-1:0]    mid_lzc;

    // thermometer zeros are exactly the leading zeros of the operand
    function automatic logic [CW-1:0] zero_count(input logic [WIDTH-1:0] t);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + CW'(!t[i]);
        return n;
    endfunction

    always_comb begin
        rev = '0;
        for (int i = 0; i < WIDTH; i++) rev[i] = da[WIDTH-1-i];
    end

    au_lzc_norm_prefix #(.WIDTH(WIDTH), .ARCH(ARCH)) u_prefix (
        .x (rev),
        .y (therm)
    );

    assign ready_b  = !vb || out_ready;
    assign ready_a  = !va || ready_mid;
    assign in_ready = ready_a;

`ifdef AU_LZC_NORM_PIPE_EN
    logic             vp;
    logic [WIDTH-1:0] dp, tp;

    assign ready_mid = !vp || ready_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vp <= 1'b0;
            dp <= '0;
            tp <= '0;
        end else if (ready_mid) begin
            vp <= va;
            dp <= da;
            tp <= therm;
        end
    end

    assign mid_v   = vp;
    assign mid_d   = dp;
    assign mid_lzc = zero_count(tp);
`else
    assign ready_mid = ready_b;
    assign mid_v     = va;
    assign mid_d     = da;
    assign mid_lzc   = zero_count(therm);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            va <= 1'b0;
            da <= '0;
        end else if (ready_a) begin
            va <= in_valid;
            da <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vb   <= 1'b0;
            db   <= '0;
            lzcb <= '0;
        end else if (ready_b) begin
            vb   <= mid_v;
            db   <= mid_d;
            lzcb <= mid_lzc;
        end
    end

    assign out_valid = vb;
    assign out_data  = db << lzcb;
    assign out_lzc   = lzcb;
    assign out_zero  = (lzcb == CW'(WIDTH));

endmodule

// File: tb/tb_au_lzc_norm.sv
// tb/tb_au_lzc_norm.sv - scoreboard bench: three ARCH variants at WIDTH 16 plus WIDTH 5 and 1
module tb_au_lzc_norm;

`ifdef AU_LZC_NORM_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  lzc;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic [15:0] od16 [3];
    logic [4:0]  ol16 [3];
    logic        ov16 [3];
    logic        oz16 [3];
    logic        rdy16[3];
    logic [4:0]  od5;
    logic [2:0]  ol5;
    logic        ov5, oz5, rdy5;
    logic        od1, ol1, ov1, oz1, rdy1;

    logic [15:0] od [5];
    logic [4:0]  ol [5];
    logic        ov [5];
    logic        oz [5];
    logic        rdy[5];

    int   wk [5] = '{16, 16, 16, 5, 1};
    exp_t sb [5][16384];
    int   wp [5];
    int   rp [5];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_arch
        au_lzc_norm #(.WIDTH(16), .ARCH(g)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16[g]), .in_data(in_data),
            .out_valid(ov16[g]), .out_ready(out_ready), .out_data(od16[g]), .out_lzc(ol16[g]),
            .out_zero(oz16[g])
        );
    end

    au_lzc_norm #(.WIDTH(5), .ARCH(1)) u_w5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy5), .in_data(in_data[4:0]),
        .out_valid(ov5), .out_ready(out_ready), .out_data(od5), .out_lzc(ol5), .out_zero(oz5)
    );

    au_lzc_norm #(.WIDTH(1), .ARCH(0)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data[0]),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_lzc(ol1), .out_zero(oz1)
    );

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            od[k] = od16[k]; ol[k] = ol16[k]; ov[k] = ov16[k]; oz[k] = oz16[k]; rdy[k] = rdy16[k];
        end
        od[3] = {11'b0, od5}; ol[3] = {2'b0, ol5}; ov[3] = ov5; oz[3] = oz5; rdy[3] = rdy5;
        od[4] = {15'b0, od1}; ol[4] = {4'b0, ol1}; ov[4] = ov1; oz[4] = oz1; rdy[4] = rdy1;
    end

    // reference: scan from the top bit for the first one, then shift by the scan length
    function automatic exp_t model(input int w, input logic [15:0] op);
        exp_t        e;
        logic [15:0] mask, v;
        int          lz;
        mask = 16'((32'd1 << w) - 1);
        v    = op & mask;
        lz   = 0;
        while (lz < w && v[w-1-lz] == 1'b0) lz++;
        e.data = 16'(v << lz) & mask;
        e.lzc  = 5'(lz);
        e.zero = (lz == w);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [15:0] op, output int stall);
        in_valid = 1'b1;
        in_data  = op;
        stall    = 0;
        @(negedge clk);
        while (!rdy[0] && stall < 100) begin
            @(negedge clk);
            stall++;
        end
        if (stall >= 100) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] op);
        int st;
        push_op(op, st);
        in_valid = 1'b0;
    endtask

    task automatic check_drained(input string name);
        for (int k = 0; k < 5; k++) chk($sformatf("%s_inst%0d_outstanding", name, k), rp[k], wp[k]);
    endtask

    task automatic run_main();
        int          edges, st0, st1, idx, cyc;
        logic        acc;
        logic [15:0] ops [4];
        ops = '{16'h0100, 16'h0010, 16'h0001, 16'h4000};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        idle(2);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("reset_in_ready%0d", k), rdy[k], 1);
            chk($sformatf("reset_out_valid%0d", k), ov[k], 0);
            chk($sformatf("reset_out_data%0d", k), od[k], 0);
            chk($sformatf("reset_out_lzc%0d", k), ol[k], 0);
            chk($sformatf("reset_out_zero%0d", k), oz[k], 0);
        end
        rst = 1'b0;

        send(16'h0001);
        edges = 1;
        @(negedge clk);
        while (!ov[0] && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk("latency", edges, LAT);
        idle(LAT + 2);

        send(16'h0000);
        idle(LAT + 2);

        push_op(16'hFFFF, st0);
        push_op(16'h00F0, st1);
        in_valid = 1'b0;
        chk("b2b_stalls", st0 + st1, 0);
        edges = 0;
        @(negedge clk);
        while (!ov[0] && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk("b2b_first_lzc", ol[0], 0);
        @(negedge clk);
        chk("b2b_second_valid", ov[0], 1);
        chk("b2b_second_lzc", ol[0], 8);
        idle(LAT + 2);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        idx       = 0;
        for (int c = 0; c < 6; c++) begin
            in_data = ops[idx];
            @(negedge clk);
            acc = rdy[0];
            if (ov[0]) begin
                chk("bp_hold_data", od[0], 16'h8000);
                chk("bp_hold_lzc", ol[0], 7);
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        chk("bp_accepts", idx, LAT);
        @(negedge clk);
        chk("bp_in_ready_low", rdy[0], 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cyc = 0;
        while (idx < 4 && cyc < 50) begin
            in_data = ops[idx];
            @(negedge clk);
            acc = rdy[0];
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        idle(LAT + 3);
        check_drained("bp");

        out_ready = 1'b0;
        push_op(16'h0003, st0);
        push_op(16'h0300, st1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("midrst_out_valid%0d", k), ov[k], 0);
            chk($sformatf("midrst_in_ready%0d", k), rdy[k], 1);
            chk($sformatf("midrst_out_lzc%0d", k), ol[k], 0);
            rp[k] = wp[k];
        end
        idle(2);
        rst = 1'b0;
        out_ready = 1'b1;
        send(16'h8000);
        idle(LAT + 3);
        check_drained("midrst");

        cyc = 0;
        st0 = wp[0];
        while (wp[0] < st0 + 10000 && cyc < 60000) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 16'($urandom) >> $urandom_range(0, 16);
            out_ready = ($urandom % 4) != 0;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 60000) chk("random_timeout", 0, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(LAT + 3);
        check_drained("random");
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            wp[k] = 0;
            rp[k] = 0;
        end
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    for (int k = 0; k < 5; k++) begin
                        if (in_valid && rdy[k] && wp[k] < 16384) begin
                            sb[k][wp[k]] = model(wk[k], in_data);
                            wp[k]++;
                        end
                        if (ov[k] && out_ready) begin
                            if (rp[k] >= wp[k]) begin
                                chk($sformatf("inst%0d_unexpected_output", k), 1, 0);
                            end else begin
                                chk($sformatf("inst%0d_data", k), od[k], sb[k][rp[k]].data);
                                chk($sformatf("inst%0d_lzc", k), ol[k], sb[k][rp[k]].lzc);
                                chk($sformatf("inst%0d_zero", k), oz[k], sb[k][rp[k]].zero);
                                rp[k]++;
                            end
                        end
                    end
                end
            end
            run_main();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
